dot_ctrl: RTL

DOT_CTRL -- requirements
Module: dot_ctrl

---
 rtl/dot_ctrl_if.sv | 33 +++
 rtl/dot_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/dot_ctrl_if.sv
// Control/data bus of the dot-product sequencer: job request, operand buffer
// read port, mac control and the result handshake.
interface dot_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic                     start;
    logic [ADDR_W:0]          len;
    logic [ADDR_W-1:0]        base_addr;
    logic                     busy;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_a;
    logic signed [DATA_W-1:0] rd_b;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [DATA_W-1:0] mac_out;
    logic                     res_valid;
    logic signed [DATA_W-1:0] res_data;
    logic                     res_ready;

    modport slave (
        input  start, len, base_addr, rd_a, rd_b, mac_out, res_ready,
        output busy, rd_en, rd_addr, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data
    );

    modport master (
        output start, len, base_addr, rd_a, rd_b, mac_out, res_ready,
        input  busy, rd_en, rd_addr, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data
    );
endinterface

// File: rtl/dot_ctrl.sv
// Dot-product sequencer: clears an external mac, streams N operand pairs from a
// buffer into it, then presents the result. Optional macro DOT_CTRL_RELU_EN clamps negative results to 0.
module dot_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input logic       clk,
    input logic       reset,
    dot_ctrl_if.slave bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_en_d, mac_clr_d, busy_d, res_valid_d;

    // Next state and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        rd_addr_d = bus.rd_addr;
        rd_en_d   = 1'b0;
        mac_clr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CLEAR;
                    len_d     = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                    base_d    = bus.base_addr;
                    mac_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                if (len_q != '0) begin
                    state_d   = FETCH;
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q;
                    cnt_d     = LEN_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            FETCH: begin
                // cnt_q counts reads already issued; address wraps naturally
                if (cnt_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = bus.rd_addr + ADDR_W'(1);
                    cnt_d     = cnt_q + LEN_W'(1);
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            base_q        <= '0;
            bus.rd_addr   <= '0;
            bus.rd_en     <= 1'b0;
            bus.mac_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            bus.rd_addr   <= rd_addr_d;
            bus.rd_en     <= rd_en_d;
            bus.mac_clr   <= mac_clr_d;
            bus.mac_en    <= bus.rd_en;
            bus.busy      <= busy_d;
            bus.res_valid <= res_valid_d;
        end
    end

    assign bus.mac_a = bus.rd_a;
    assign bus.mac_b = bus.rd_b;

    // mac_out is frozen in DONE (mac_en low), so the result is stable while waiting
    always_comb begin
        bus.res_data = DATA_W'(0);
        if (state_q == DONE) begin
`ifdef DOT_CTRL_RELU_EN
            bus.res_data = bus.mac_out[DATA_W-1] ? DATA_W'(0) : bus.mac_out;
`else
            bus.res_data = bus.mac_out;
`endif
        end
    end
endmodule
